semaforo_ctrl: RTL and testbench
================================

// Module: semaforo_ctrl
// PURPOSE
//  4-approach traffic-light controller producing the 12-bit semaforos bus that is probed by the GAO debug core.
//  Moore FSM with a 1 s prescaler, per-phase countdown, pedestrian-request green truncation and a night (flashing amber) mode.
//  Sits directly upstream of the debug/probe top; semaforos also drives the board lamps.
// PARAMETERS
//  TICK_DIV   27_000_000  clk cycles per 1 s tick (>=2; bench uses 4)
//  T_GREEN    10          green phase length in ticks (1..255)
//  T_YELLOW   3           yellow phase length in ticks (1..255)
//  T_ALLRED   1           all-red clearance length in ticks (1..255)
//  T_PED_MIN  2           remaining green, in ticks, after a pedestrian request (1..T_GREEN)
// PORTS
//  clk        in   1   single system clock, rising edge
//  rst        in   1   synchronous, active-high reset
//  night_i    in   1   1 = flashing-amber night mode (level, sampled on tick)
//  ped_req_i  in   1   pedestrian request, any pulse >=1 clk, latched
//  semaforos  out  12  [11:9]=N, [8:6]=S, [5:3]=E, [2:0]=W; each {R,Y,G}
//  state_o    out  3   current FSM state encoding (debug)
//  tick_o     out  1   1-clk 1 s tick strobe (debug)
// BEHAVIOUR
//  Prescaler: pcnt counts 0..TICK_DIV-1 and wraps; tick_o=1 exactly on the cycle where pcnt==TICK_DIV-1.
//  States: 0 NS_G, 1 NS_Y, 2 AR_NS, 3 EW_G, 4 EW_Y, 5 AR_EW, 6 NIGHT; 7 unused -> AR_EW next clk.
//  Sequence: AR_EW->NS_G->NS_Y->AR_NS->EW_G->EW_Y->AR_EW.
//  Timer secs (8b): loaded with duration-1 on state entry; decrements on tick; on tick with secs==0 state advances (same edge).
//  Every phase therefore lasts exactly duration*TICK_DIV clk when entry is tick-aligned (always, after reset).
//  Output decode (Moore, from state register; no extra latency):
//   NS_G 12'h264, NS_Y 12'h4A4, AR_NS/AR_EW 12'h924, EW_G 12'h909, EW_Y 12'h912,
//   NIGHT 12'h492 when blink=1, 12'h000 when blink=0.
//  Reset: pcnt=0, state=AR_EW, secs=T_ALLRED-1, ped latch=0, blink=1; semaforos=12'h924, state_o=5, tick_o=0.
//  Reset mid-operation: same values on the next edge regardless of state; no partial phase retained.
//  Pedestrian: ped_req_i sets ped_lat. In NS_G/EW_G with ped_lat=1 and secs>T_PED_MIN-1: secs<=T_PED_MIN-1, ped_lat cleared.
//   In green with secs<=T_PED_MIN-1: ped_lat cleared, no change. Outside green: ped_lat held until next green entry.
//   ped_req_i coincident with tick: truncation wins over decrement that cycle (secs=T_PED_MIN-1, not -2).
//  Night: on tick with night_i=1 and state!=NIGHT -> NIGHT (from any state), blink=1; ped_lat cleared.
//   In NIGHT blink toggles on every tick; ped_req_i ignored.
//   On tick with night_i=0 in NIGHT -> AR_EW, secs=T_ALLRED-1.
//  Priority on a tick: rst > night entry/exit > phase expiry > ped truncation > decrement.
//  Invariant: never green on both axes; any green is preceded by >=1 AR tick.
// TESTING (bench: TICK_DIV=4, defaults otherwise)
//  Reset 2 clk -> semaforos=12'h924, state_o=5; first tick (clk 4) -> 12'h264, state_o=0.
//  Free run -> NS_G 40 clk, NS_Y 12 (12'h4A4), AR_NS 4 (12'h924), EW_G 40 (12'h909), EW_Y 12 (12'h912), AR_EW 4; period 112 clk.
//  ped_req_i pulse in NS_G at secs=8 -> exactly 2 more ticks (8 clk) of 12'h264, then 12'h4A4; request in NS_Y -> next EW_G lasts 2 ticks.
//  night_i=1 mid EW_G -> next tick 12'h492, toggling 12'h000/12'h492 each tick; night_i=0 -> 12'h924 for 1 tick then 12'h264.
//  rst pulse mid NS_Y and with ped_lat pending -> 12'h924 next clk; following NS_G lasts full 40 clk (latch cleared).
//  Assertion over all runs: no cycle with a G bit set on both N/S and E/W groups.

Source files
------------

// File: rtl/semaforo_ctrl.sv
// semaforo_ctrl: four-approach traffic-light controller.
//
// Moore FSM with a 1 s prescaler, per-phase countdown timer, pedestrian
// green truncation and a flashing-amber night mode. The 12-bit semaforos bus
// drives the board lamps and is probed by the debug core.
//
// Ports
//   clk        system clock, rising edge
//   rst        synchronous active-high reset
//   night_i    night mode level, acted on only on a tick
//   ped_req_i  pedestrian request pulse (>=1 clk), latched internally
//   semaforos  lamp bus: [11:9]=N [8:6]=S [5:3]=E [2:0]=W, each {R,Y,G}
//   state_o    current FSM state encoding
//   tick_o     one-clock 1 s tick strobe
module semaforo_ctrl #(
    parameter int TICK_DIV  = 27_000_000,
    parameter int T_GREEN   = 10,
    parameter int T_YELLOW  = 3,
    parameter int T_ALLRED  = 1,
    parameter int T_PED_MIN = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        night_i,
    input  logic        ped_req_i,
    output logic [11:0] semaforos,
    output logic [2:0]  state_o,
    output logic        tick_o
);

    typedef enum logic [2:0] {
        ST_NS_G  = 3'd0,
        ST_NS_Y  = 3'd1,
        ST_AR_NS = 3'd2,
        ST_EW_G  = 3'd3,
        ST_EW_Y  = 3'd4,
        ST_AR_EW = 3'd5,
        ST_NIGHT = 3'd6,
        ST_BAD   = 3'd7
    } state_t;

    localparam int            PW          = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PCNT_LAST   = PW'(TICK_DIV - 1);
    localparam logic [7:0]    SECS_PED    = 8'(T_PED_MIN - 1);
    localparam logic [7:0]    SECS_ALLRED = 8'(T_ALLRED - 1);

    // Timer load value (duration-1) for the phase being entered.
    function automatic logic [7:0] phase_secs(input state_t s);
        case (s)
            ST_NS_G, ST_EW_G: phase_secs = 8'(T_GREEN - 1);
            ST_NS_Y, ST_EW_Y: phase_secs = 8'(T_YELLOW - 1);
            default:          phase_secs = SECS_ALLRED;
        endcase
    endfunction

    function automatic state_t next_phase(input state_t s);
        case (s)
            ST_AR_EW: next_phase = ST_NS_G;
            ST_NS_G:  next_phase = ST_NS_Y;
            ST_NS_Y:  next_phase = ST_AR_NS;
            ST_AR_NS: next_phase = ST_EW_G;
            ST_EW_G:  next_phase = ST_EW_Y;
            default:  next_phase = ST_AR_EW;
        endcase
    endfunction

    logic [PW-1:0] pcnt;
    logic          tick;
    state_t        state, state_nxt;
    logic [7:0]    secs, secs_nxt;
    logic          ped_lat, ped_nxt;
    logic          blink, blink_nxt;
    logic          is_green;
    logic          ped_eff;

    // Prescaler: free-running 0..TICK_DIV-1
    assign tick = (pcnt == PCNT_LAST);

    always_ff @(posedge clk) begin
        if (rst || tick) begin
            pcnt <= '0;
        end else begin
            pcnt <= pcnt + PW'(1);
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_AR_EW;
            secs    <= SECS_ALLRED;
            ped_lat <= 1'b0;
            blink   <= 1'b1;
        end else begin
            state   <= state_nxt;
            secs    <= secs_nxt;
            ped_lat <= ped_nxt;
            blink   <= blink_nxt;
        end
    end

    // Next-state logic
    assign is_green = (state == ST_NS_G) || (state == ST_EW_G);
    // A request arriving this very cycle counts, so a request coincident
    // with a tick truncates instead of letting the tick decrement first.
    assign ped_eff  = ped_lat || ped_req_i;

    always_comb begin
        state_nxt = state;
        secs_nxt  = secs;
        ped_nxt   = ped_lat;
        blink_nxt = blink;
        if (state == ST_BAD) begin
            state_nxt = ST_AR_EW;
            secs_nxt  = SECS_ALLRED;
            ped_nxt   = ped_eff;
        end else if (state == ST_NIGHT) begin
            ped_nxt = 1'b0;
            if (tick) begin
                if (night_i) begin
                    blink_nxt = ~blink;
                end else begin
                    state_nxt = ST_AR_EW;
                    secs_nxt  = SECS_ALLRED;
                    blink_nxt = 1'b1;
                end
            end
        end else if (tick && night_i) begin
            state_nxt = ST_NIGHT;
            blink_nxt = 1'b1;
            ped_nxt   = 1'b0;
        end else begin
            ped_nxt = ped_eff;
            if (tick && (secs == 8'd0)) begin
                state_nxt = next_phase(state);
                secs_nxt  = phase_secs(next_phase(state));
            end else if (is_green && ped_eff && (secs > SECS_PED)) begin
                secs_nxt = SECS_PED;
            end else if (tick) begin
                secs_nxt = secs - 8'd1;
            end
            // A green consumes any pending request, truncating or not.
            if (is_green && ped_eff) begin
                ped_nxt = 1'b0;
            end
        end
    end

    // Output decode
    always_comb begin
        case (state)
            ST_NS_G:  semaforos = 12'h264;
            ST_NS_Y:  semaforos = 12'h4A4;
            ST_EW_G:  semaforos = 12'h909;
            ST_EW_Y:  semaforos = 12'h912;
            ST_NIGHT: semaforos = blink ? 12'h492 : 12'h000;
            default:  semaforos = 12'h924;
        endcase
    end

    assign state_o = state;
    assign tick_o  = tick;

endmodule

// File: tb/tb_semaforo_ctrl.sv
module tb_semaforo_ctrl;

    localparam int TICK_DIV  = 4;
    localparam int T_GREEN   = 10;
    localparam int T_YELLOW  = 3;
    localparam int T_ALLRED  = 1;
    localparam int T_PED_MIN = 2;

    logic        clk;
    logic        rst;
    logic        night_i;
    logic        ped_req_i;
    logic [11:0] semaforos;
    logic [2:0]  state_o;
    logic        tick_o;

    semaforo_ctrl #(
        .TICK_DIV (TICK_DIV),
        .T_GREEN  (T_GREEN),
        .T_YELLOW (T_YELLOW),
        .T_ALLRED (T_ALLRED),
        .T_PED_MIN(T_PED_MIN)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .night_i  (night_i),
        .ped_req_i(ped_req_i),
        .semaforos(semaforos),
        .state_o  (state_o),
        .tick_o   (tick_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: position in the six-phase ring plus whole ticks left.
    localparam logic [11:0] PAT [6] = '{12'h264, 12'h4A4, 12'h924, 12'h909, 12'h912, 12'h924};
    localparam int          DUR [6] = '{T_GREEN, T_YELLOW, T_ALLRED, T_GREEN, T_YELLOW, T_ALLRED};

    int m_idx, m_left, m_cyc;
    bit m_night, m_blink, m_ped, m_valid;

    initial m_valid = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_step();
        bit tk, green, pe;
        if (rst) begin
            m_idx = 5; m_left = T_ALLRED; m_ped = 0; m_blink = 1;
            m_night = 0; m_cyc = 0; m_valid = 1;
        end else if (m_valid) begin
            tk    = (m_cyc == TICK_DIV - 1);
            m_cyc = (m_cyc + 1) % TICK_DIV;
            green = (m_idx == 0) || (m_idx == 3);
            if (m_night) begin
                m_ped = 0;
                if (tk) begin
                    if (night_i) m_blink = !m_blink;
                    else begin
                        m_night = 0; m_idx = 5; m_left = T_ALLRED; m_blink = 1;
                    end
                end
            end else if (tk && night_i) begin
                m_night = 1; m_blink = 1; m_ped = 0;
            end else begin
                pe = m_ped || ped_req_i;
                if (tk && m_left == 1) begin
                    m_idx  = (m_idx + 1) % 6;
                    m_left = DUR[m_idx];
                end else if (green && pe && m_left > T_PED_MIN) begin
                    m_left = T_PED_MIN;
                end else if (tk) begin
                    m_left--;
                end
                m_ped = green ? 1'b0 : pe;
            end
        end
    endtask

    // One clock: model follows the edge, outputs sampled on the falling edge.
    task automatic cyc();
        logic [11:0] exp_sem;
        logic [2:0]  exp_st;
        @(posedge clk);
        model_step();
        @(negedge clk);
        if (m_valid) begin
            exp_sem = m_night ? (m_blink ? 12'h492 : 12'h000) : PAT[m_idx];
            exp_st  = m_night ? 3'd6 : 3'(m_idx);
            chk("model_semaforos", 32'(semaforos), 32'(exp_sem));
            chk("model_state", 32'(state_o), 32'(exp_st));
            chk("model_tick", 32'(tick_o), 32'(m_cyc == TICK_DIV - 1));
            chk("dual_green", 32'((semaforos[9] | semaforos[6]) & (semaforos[3] | semaforos[0])), 32'(0));
        end
    endtask

    task automatic wait_pat(input logic [11:0] pat);
        int n = 0;
        while (semaforos !== pat && n < 400) begin
            cyc();
            n++;
        end
        chk("wait_pattern", 32'(semaforos), 32'(pat));
    endtask

    // Counts cycles the pattern stays on, starting at its first cycle.
    task automatic run_len(input logic [11:0] pat, input int exp, input string nm);
        int n = 0;
        while (semaforos === pat && n < 400) begin
            cyc();
            n++;
        end
        chk(nm, 32'(n), 32'(exp));
    endtask

    typedef struct {
        logic        r;
        logic        ni;
        logic        pd;
        logic [11:0] sem;
        logic [2:0]  st;
        logic        tk;
    } vec_t;

    vec_t tbl [30];

    initial begin
        rst = 1'b1; night_i = 1'b0; ped_req_i = 1'b0;

        // reset, first tick
        tbl[0]  = '{1'b1, 1'b0, 1'b0, 12'h924, 3'd5, 1'b0};
        tbl[1]  = '{1'b1, 1'b0, 1'b0, 12'h924, 3'd5, 1'b0};
        tbl[2]  = '{1'b0, 1'b0, 1'b0, 12'h924, 3'd5, 1'b0};
        tbl[3]  = '{1'b0, 1'b0, 1'b0, 12'h924, 3'd5, 1'b0};
        tbl[4]  = '{1'b0, 1'b0, 1'b0, 12'h924, 3'd5, 1'b1};
        tbl[5]  = '{1'b0, 1'b0, 1'b0, 12'h264, 3'd0, 1'b0};
        tbl[6]  = '{1'b0, 1'b0, 1'b0, 12'h264, 3'd0, 1'b0};
        // night entry from NS_G, blink, exit through all-red
        tbl[7]  = '{1'b0, 1'b1, 1'b0, 12'h264, 3'd0, 1'b0};
        tbl[8]  = '{1'b0, 1'b1, 1'b0, 12'h264, 3'd0, 1'b1};
        tbl[9]  = '{1'b0, 1'b1, 1'b0, 12'h492, 3'd6, 1'b0};
        tbl[10] = '{1'b0, 1'b1, 1'b0, 12'h492, 3'd6, 1'b0};
        tbl[11] = '{1'b0, 1'b1, 1'b0, 12'h492, 3'd6, 1'b0};
        tbl[12] = '{1'b0, 1'b1, 1'b0, 12'h492, 3'd6, 1'b1};
        tbl[13] = '{1'b0, 1'b1, 1'b0, 12'h000, 3'd6, 1'b0};
        tbl[14] = '{1'b0, 1'b1, 1'b0, 12'h000, 3'd6, 1'b0};
        tbl[15] = '{1'b0, 1'b1, 1'b0, 12'h000, 3'd6, 1'b0};
        tbl[16] = '{1'b0, 1'b1, 1'b0, 12'h000, 3'd6, 1'b1};
        tbl[17] = '{1'b0, 1'b0, 1'b0, 12'h924, 3'd5, 1'b0};
        tbl[18] = '{1'b0, 1'b0, 1'b0, 12'h924, 3'd5, 1'b0};
        tbl[19] = '{1'b0, 1'b0, 1'b0, 12'h924, 3'd5, 1'b0};
        tbl[20] = '{1'b0, 1'b0, 1'b0, 12'h924, 3'd5, 1'b1};
        tbl[21] = '{1'b0, 1'b0, 1'b0, 12'h264, 3'd0, 1'b0};
        // pedestrian request on the first NS_G cycle: two ticks left
        tbl[22] = '{1'b0, 1'b0, 1'b1, 12'h264, 3'd0, 1'b0};
        tbl[23] = '{1'b0, 1'b0, 1'b0, 12'h264, 3'd0, 1'b0};
        tbl[24] = '{1'b0, 1'b0, 1'b0, 12'h264, 3'd0, 1'b1};
        tbl[25] = '{1'b0, 1'b0, 1'b0, 12'h264, 3'd0, 1'b0};
        tbl[26] = '{1'b0, 1'b0, 1'b0, 12'h264, 3'd0, 1'b0};
        tbl[27] = '{1'b0, 1'b0, 1'b0, 12'h264, 3'd0, 1'b0};
        tbl[28] = '{1'b0, 1'b0, 1'b0, 12'h264, 3'd0, 1'b1};
        tbl[29] = '{1'b0, 1'b0, 1'b0, 12'h4A4, 3'd1, 1'b0};

        for (int i = 0; i < 30; i++) begin
            rst = tbl[i].r; night_i = tbl[i].ni; ped_req_i = tbl[i].pd;
            cyc();
            chk("vec_semaforos", 32'(semaforos), 32'(tbl[i].sem));
            chk("vec_state", 32'(state_o), 32'(tbl[i].st));
            chk("vec_tick", 32'(tick_o), 32'(tbl[i].tk));
        end

        // free-run phase lengths
        rst = 1'b1; cyc(); rst = 1'b0;
        wait_pat(12'h264);
        run_len(12'h264, 40, "run_ns_g");
        run_len(12'h4A4, 12, "run_ns_y");
        run_len(12'h924, 4,  "run_ar_ns");
        run_len(12'h909, 40, "run_ew_g");
        run_len(12'h912, 12, "run_ew_y");
        run_len(12'h924, 4,  "run_ar_ew");
        run_len(12'h264, 40, "run_ns_g2");

        // request in NS_G with secs=8: 8 more clocks of green
        wait_pat(12'h264);
        repeat (4) cyc();
        ped_req_i = 1'b1; cyc(); ped_req_i = 1'b0;
        run_len(12'h264, 7, "ped_ns_g_rest");
        // request during NS_Y shortens the following EW_G
        ped_req_i = 1'b1; cyc(); ped_req_i = 1'b0;
        run_len(12'h4A4, 11, "ped_ns_y_rest");
        run_len(12'h924, 4,  "ped_ar_ns");
        run_len(12'h909, 8,  "ped_ew_g_short");
        run_len(12'h912, 12, "ped_ew_y");

        // night mode entered mid EW_G
        wait_pat(12'h909);
        repeat (6) cyc();
        night_i = 1'b1;
        wait_pat(12'h492);
        repeat (13) cyc();
        night_i = 1'b0;
        wait_pat(12'h924);
        run_len(12'h924, 4, "night_exit_ar");
        chk("night_exit_ns_g", 32'(state_o), 32'(0));

        // reset mid NS_Y with a request pending
        wait_pat(12'h4A4);
        repeat (2) cyc();
        ped_req_i = 1'b1; cyc(); ped_req_i = 1'b0;
        cyc();
        rst = 1'b1; cyc(); rst = 1'b0;
        chk("rst_mid_semaforos", 32'(semaforos), 32'(12'h924));
        run_len(12'h924, 4,  "rst_ar_ew");
        run_len(12'h264, 40, "rst_ns_g_full");

        // randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            ped_req_i = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 199) == 0) night_i = ~night_i;
            rst = ($urandom_range(0, 399) == 0);
            cyc();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
